dyn_add_sched: RTL and testbench
================================

// Module: dyn_add_sched
// PURPOSE
//  Clocked scheduler that shares one self-timed dynamic ripple adder among NREQ requesters.
//  Per operation:
//   - round-robin arbitration between requesters
//   - latch operands and drive them onto the adder
//   - pulse the adder "first" signal
//   - wait a data-dependent number of cycles estimated from the propagate pattern
//   - capture sum/carry and return it with a valid/ready handshake
//  Sits between the requesting datapath units and the adder instance.
// PARAMETERS
//  WIDTH  32  operand/sum width in bits
//  NREQ   4   number of requesters (>=2)
//  SEG    8   propagate-segment width used for wait estimation; WIDTH % SEG == 0
//  NSEG   WIDTH/SEG  derived; maximum wait W = NSEG+1
// PORTS
//  clk          in   1           single clock, rising edge
//  rst_n        in   1           synchronous active-low reset
//  req_valid    in   NREQ        requester i has an operation pending
//  req_ready    out  NREQ        one-hot grant; handshake when valid&ready
//  req_a        in   NREQ*WIDTH  operand A, requester i in slice [i*WIDTH +: WIDTH]
//  req_b        in   NREQ*WIDTH  operand B, same packing
//  req_cin      in   NREQ        carry-in per requester
//  adder_a      out  WIDTH       operand A to adder (registered)
//  adder_b      out  WIDTH       operand B to adder (registered)
//  adder_cin    out  1           carry-in to adder (registered)
//  adder_first  out  1           "F" start pulse to adder, 1 cycle
//  adder_sum    in   WIDTH       adder sum
//  adder_cout   in   1           adder carry-out
//  rsp_valid    out  1           result available
//  rsp_ready    in   1           consumer accepts result
//  rsp_id       out  $clog2(NREQ) index of requester that owns the result
//  rsp_sum      out  WIDTH       captured sum
//  rsp_cout     out  1           captured carry-out
//  busy         out  1           high in every state except IDLE
// BEHAVIOUR
//  Reset values: all outputs 0; rr pointer = 0; state = IDLE.
//  Reset mid-operation discards the operation; no response is produced.
//  FSM IDLE -> LAUNCH -> WAIT -> CAPTURE -> RESP -> IDLE.
//  IDLE
//   - req_ready = one-hot grant from round-robin over req_valid, priority starting at the pointer.
//   - On handshake: latch a/b/cin/id, compute W, go LAUNCH.
//   - Pointer becomes (granted+1) mod NREQ.
//   - No valid: req_ready = 0, stay IDLE.
//  LAUNCH
//   - adder_first = 1 for exactly this cycle.
//   - adder_a/b/cin stay stable from this cycle through CAPTURE.
//  WAIT
//   - Counter loaded with W; decrements every cycle; go CAPTURE when it reaches 1.
//   - Spends exactly W cycles in WAIT.
//  CAPTURE
//   - Register adder_sum/adder_cout into rsp_sum/rsp_cout; go RESP.
//  RESP
//   - rsp_valid = 1; rsp_* held stable until rsp_ready.
//   - On rsp_ready go IDLE; rsp_valid drops the next cycle.
//   - req_ready = 0 in all non-IDLE states.
//  W estimation, from P = A ^ B:
//   - seg_k = &P[k*SEG +: SEG] for k = 0..NSEG-1.
//   - W = 1 + longest run of consecutive seg_k = 1; range 1..NSEG+1.
//  Latency: handshake in cycle t -> rsp_valid in cycle t+W+3.
//  Minimum occupancy per operation: W+4 cycles.
//  Boundary conditions:
//   - req_valid dropped while not granted: ignored, no effect.
//   - rsp_ready held high continuously: one-cycle RESP.
//   - rsp_ready high outside RESP: ignored.
//   - All requesters valid: strict rotation 0,1,2,3,0...
//   - Counter width: $clog2(NSEG+2).
// STRUCTURE
//  Package dyn_add_pkg:
//   - state enum (IDLE, LAUNCH, WAIT, CAPTURE, RESP)
//   - default WIDTH/SEG constants
//   - function est_wait(P) returning W
//  Sub-module dyn_add_rr_arb (NREQ):
//   - valid vector + pointer in -> one-hot grant + encoded index out
//   - purely combinational
//  Pointer register stays in dyn_add_sched.
// TESTING
//  1. Req0 A=0, B=0, cin=0 -> W=1; adder_first in t+1; rsp_valid at t+4; sum=0, cout=0, id=0.
//  2. Req2 A=FFFFFFFF, B=0, cin=1 -> all segments propagate, W=5; rsp_valid at t+8; sum=0, cout=1, id=2.
//  3. A=000000FF, B=0000FF00 -> segs 1,1,0,0, W=3; sum=0000FFFF; rsp_valid at t+6.
//  4. All 4 req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0; rsp_id matches the grant order.
//  5. rsp_ready=0 for 10 cycles in RESP -> rsp_* stable, req_ready=0 throughout; accepted on the first rsp_ready.
//  6. rst_n=0 during WAIT -> next cycle all outputs 0, state IDLE; the following request starts from pointer 0.

Source files
------------

// File: rtl/dyn_add_pkg.sv
// Shared types and helpers for the dynamic-adder scheduler: FSM state encoding,
// default geometry and the propagate-run based wait estimate.
package dyn_add_pkg;

  localparam int DEF_WIDTH = 32;
  localparam int DEF_SEG   = 8;
  localparam int DEF_NSEG  = DEF_WIDTH / DEF_SEG;
  localparam int MAX_NSEG  = 64;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT,
    CAPTURE,
    RESP
  } state_e;

  // Worst-case carry travel grows with the longest chain of fully propagating segments.
  function automatic int run_wait(input logic [MAX_NSEG-1:0] seg, input int nseg);
    int run;
    int best;
    run  = 0;
    best = 0;
    for (int k = 0; k < MAX_NSEG; k++) begin
      if (k < nseg && seg[k]) begin
        run = run + 1;
        if (run > best) best = run;
      end else begin
        run = 0;
      end
    end
    return best + 1;
  endfunction

  function automatic int est_wait(input logic [DEF_WIDTH-1:0] p);
    logic [MAX_NSEG-1:0] seg;
    seg = '0;
    for (int k = 0; k < DEF_NSEG; k++) seg[k] = &p[k*DEF_SEG +: DEF_SEG];
    return run_wait(seg, DEF_NSEG);
  endfunction

endpackage

// File: rtl/dyn_add_sched_if.sv
// Bundle of requester, adder and response signals around the scheduler.
// The slave side is the scheduler; the master side is its environment.
interface dyn_add_sched_if
  import dyn_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 4
);
  localparam int IDW = $clog2(NREQ);

  logic [NREQ-1:0]       req_valid;
  logic [NREQ-1:0]       req_ready;
  logic [NREQ*WIDTH-1:0] req_a;
  logic [NREQ*WIDTH-1:0] req_b;
  logic [NREQ-1:0]       req_cin;

  logic [WIDTH-1:0]      adder_a;
  logic [WIDTH-1:0]      adder_b;
  logic                  adder_cin;
  logic                  adder_first;
  logic [WIDTH-1:0]      adder_sum;
  logic                  adder_cout;

  logic                  rsp_valid;
  logic                  rsp_ready;
  logic [IDW-1:0]        rsp_id;
  logic [WIDTH-1:0]      rsp_sum;
  logic                  rsp_cout;

  modport master (
    output req_valid, req_a, req_b, req_cin, adder_sum, adder_cout, rsp_ready,
    input  req_ready, adder_a, adder_b, adder_cin, adder_first,
           rsp_valid, rsp_id, rsp_sum, rsp_cout
  );

  modport slave (
    input  req_valid, req_a, req_b, req_cin, adder_sum, adder_cout, rsp_ready,
    output req_ready, adder_a, adder_b, adder_cin, adder_first,
           rsp_valid, rsp_id, rsp_sum, rsp_cout
  );
endinterface

// File: rtl/dyn_add_rr_arb.sv
// Combinational round-robin arbiter: the first valid requester at or after the
// pointer wins, reported both one-hot and encoded.
module dyn_add_rr_arb #(
  parameter  int NREQ = 4,
  localparam int IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] valid_i,
  input  logic [IDW-1:0]  ptr_i,
  output logic [NREQ-1:0] grant_o,
  output logic [IDW-1:0]  idx_o,
  output logic            any_o
);

  logic [IDW-1:0] cand;

  always_comb begin
    grant_o = '0;
    idx_o   = '0;
    any_o   = 1'b0;
    cand    = '0;
    for (int off = 0; off < NREQ; off++) begin
      cand = IDW'((int'(ptr_i) + off) % NREQ);
      if (!any_o && valid_i[cand]) begin
        any_o         = 1'b1;
        grant_o[cand] = 1'b1;
        idx_o         = cand;
      end
    end
  end

endmodule

// File: rtl/dyn_add_sched.sv
// Shares one self-timed ripple adder among NREQ requesters: arbitrate, launch,
// wait a propagate-dependent number of cycles, then hand the result back.
module dyn_add_sched
  import dyn_add_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH,
  parameter int NREQ  = 4,
  parameter int SEG   = DEF_SEG
) (
  input  logic           clk,
  input  logic           rst_n,
  dyn_add_sched_if.slave bus,
  output logic           busy
);

  localparam int NSEG  = WIDTH / SEG;
  localparam int IDW   = $clog2(NREQ);
  localparam int CNT_W = $clog2(NSEG + 2);

  state_e              state_q, state_d;
  logic [IDW-1:0]      ptr_q, ptr_d;
  logic [IDW-1:0]      id_q;
  logic [WIDTH-1:0]    a_q, b_q, sum_q;
  logic                cin_q, cout_q;
  logic [CNT_W-1:0]    cnt_q, cnt_d;

  logic [NREQ-1:0]     grant;
  logic [IDW-1:0]      grant_idx;
  logic                grant_any;
  logic                handshake;
  logic [MAX_NSEG-1:0] seg;

  dyn_add_rr_arb #(.NREQ(NREQ)) u_arb (
    .valid_i (bus.req_valid),
    .ptr_i   (ptr_q),
    .grant_o (grant),
    .idx_o   (grant_idx),
    .any_o   (grant_any)
  );

  assign handshake = (state_q == IDLE) && grant_any;

  always_ff @(posedge clk) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (grant_any) state_d = LAUNCH;
      LAUNCH:  state_d = WAIT;
      WAIT:    if (cnt_q == CNT_W'(1)) state_d = CAPTURE;
      CAPTURE: state_d = RESP;
      RESP:    if (bus.rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    bus.req_ready   = (state_q == IDLE) ? grant : '0;
    bus.adder_first = (state_q == LAUNCH);
    bus.rsp_valid   = (state_q == RESP);
    busy            = (state_q != IDLE);
    bus.adder_a     = a_q;
    bus.adder_b     = b_q;
    bus.adder_cin   = cin_q;
    bus.rsp_id      = id_q;
    bus.rsp_sum     = sum_q;
    bus.rsp_cout    = cout_q;
  end

  // Segment flags come from the latched operands, so the estimate is ready during LAUNCH.
  always_comb begin
    seg = '0;
    for (int k = 0; k < NSEG; k++) seg[k] = &(a_q[k*SEG +: SEG] ^ b_q[k*SEG +: SEG]);
  end

  always_comb begin
    cnt_d = cnt_q;
    ptr_d = ptr_q;
    if (state_q == LAUNCH) cnt_d = CNT_W'(run_wait(seg, NSEG));
    else if (state_q == WAIT) cnt_d = cnt_q - CNT_W'(1);
    if (handshake) ptr_d = (grant_idx == IDW'(NREQ - 1)) ? '0 : grant_idx + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      id_q   <= '0;
      a_q    <= '0;
      b_q    <= '0;
      cin_q  <= 1'b0;
      cnt_q  <= '0;
      sum_q  <= '0;
      cout_q <= 1'b0;
    end else begin
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      if (handshake) begin
        a_q   <= bus.req_a[grant_idx*WIDTH +: WIDTH];
        b_q   <= bus.req_b[grant_idx*WIDTH +: WIDTH];
        cin_q <= bus.req_cin[grant_idx];
        id_q  <= grant_idx;
      end
      if (state_q == CAPTURE) begin
        sum_q  <= bus.adder_sum;
        cout_q <= bus.adder_cout;
      end
    end
  end

endmodule

// File: tb/tb_dyn_add_sched.sv
// Scoreboard bench for dyn_add_sched: requests are queued per requester, the
// expected result and arrival cycle are pushed at grant and popped at response.
module tb_dyn_add_sched;
  localparam int WIDTH = 32;
  localparam int NREQ  = 4;
  localparam int SEG   = 8;

  typedef struct {
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             cin;
  } op_t;

  typedef struct {
    int          id;
    logic [32:0] res;
    int          due;
  } exp_t;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic busy;

  op_t  reqQ[NREQ][$];
  exp_t expQ[$];
  int   grantLog[$];

  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ptrM = 0;
  bit   outstanding = 1'b0;
  int   firstCyc = -1;
  bit   inResp = 1'b0;
  bit   dropEn = 1'b0;
  int   rspMode = 0;

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  dyn_add_sched_if #(.WIDTH(WIDTH), .NREQ(NREQ)) bus ();

  dyn_add_sched #(.WIDTH(WIDTH), .NREQ(NREQ), .SEG(SEG)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  // Behavioural adder: plain addition stands in for the self-timed ripple chain.
  assign {bus.adder_cout, bus.adder_sum} = {1'b0, bus.adder_a} + {1'b0, bus.adder_b}
                                           + {32'b0, bus.adder_cin};

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic int refWait(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
    logic [WIDTH-1:0] p;
    int run;
    int best;
    p    = a ^ b;
    run  = 0;
    best = 0;
    for (int k = 0; k < WIDTH / SEG; k++) begin
      if (((p >> (k * SEG)) & 32'hFF) == 32'hFF) run++;
      else run = 0;
      if (run > best) best = run;
    end
    return best + 1;
  endfunction

  task automatic applyStimulus(input int id, input logic [WIDTH-1:0] a,
                               input logic [WIDTH-1:0] b, input logic cin);
    op_t op;
    op.a   = a;
    op.b   = b;
    op.cin = cin;
    reqQ[id].push_back(op);
  endtask

  function automatic int pendingReqs();
    int n;
    n = 0;
    for (int i = 0; i < NREQ; i++) n += reqQ[i].size();
    return n;
  endfunction

  task automatic waitDrain(input int budget);
    int n;
    n = 0;
    while ((pendingReqs() > 0 || expQ.size() > 0 || outstanding) && n < budget) begin
      @(negedge clk);
      n++;
    end
    checkOutput("drain_timeout", 64'(n >= budget), 64'd0);
    repeat (2) @(negedge clk);
  endtask

  // Requester driver: raises valid for the head of each queue, drops it after a grant.
  initial begin
    logic [NREQ-1:0] granted;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_cin   = '0;
    forever begin
      @(negedge clk);
      granted = bus.req_ready & bus.req_valid & {NREQ{rst_n}};
      @(posedge clk);
      #1;
      for (int i = 0; i < NREQ; i++) begin
        if (granted[i]) begin
          bus.req_valid[i] = 1'b0;
          void'(reqQ[i].pop_front());
        end else if (bus.req_valid[i]) begin
          if (dropEn && $urandom_range(0, 7) == 0) bus.req_valid[i] = 1'b0;
        end else if (reqQ[i].size() > 0 && (!dropEn || $urandom_range(0, 2) == 0)) begin
          bus.req_a[i*WIDTH +: WIDTH] = reqQ[i][0].a;
          bus.req_b[i*WIDTH +: WIDTH] = reqQ[i][0].b;
          bus.req_cin[i]              = reqQ[i][0].cin;
          bus.req_valid[i]            = 1'b1;
        end
      end
    end
  end

  initial begin
    bus.rsp_ready = 1'b0;
    forever begin
      @(posedge clk);
      #1;
      case (rspMode)
        0:       bus.rsp_ready = 1'b1;
        1:       bus.rsp_ready = 1'($urandom_range(0, 1));
        default: bus.rsp_ready = 1'b0;
      endcase
    end
  end

  // Checker: request side first (uses the pre-response model state), then response side.
  logic [NREQ-1:0]  expGrant;
  int               gi;
  int               wExp;
  logic [WIDTH-1:0] opA, opB;
  logic             opCin;

  always @(negedge clk) begin
    if (rst_n) begin
      expGrant = '0;
      gi       = -1;
      if (!outstanding) begin
        for (int off = 0; off < NREQ; off++) begin
          if (gi < 0 && bus.req_valid[(ptrM + off) % NREQ]) gi = (ptrM + off) % NREQ;
        end
      end
      if (gi >= 0) expGrant[gi] = 1'b1;
      checkOutput("req_ready", 64'(bus.req_ready), 64'(expGrant));
      checkOutput("adder_first", 64'(bus.adder_first), 64'(outstanding && cyc == firstCyc));
      checkOutput("busy", 64'(busy), 64'(outstanding && cyc >= firstCyc));
      if (gi >= 0) begin
        opA   = bus.req_a[gi*WIDTH +: WIDTH];
        opB   = bus.req_b[gi*WIDTH +: WIDTH];
        opCin = bus.req_cin[gi];
        wExp  = refWait(opA, opB);
        expQ.push_back('{gi, {1'b0, opA} + {1'b0, opB} + {32'b0, opCin}, cyc + wExp + 3});
        grantLog.push_back(gi);
        ptrM        = (gi + 1) % NREQ;
        outstanding = 1'b1;
        firstCyc    = cyc + 1;
      end

      if (bus.rsp_valid) begin
        if (expQ.size() == 0) begin
          checkOutput("rsp_valid_unexpected", 64'd1, 64'd0);
        end else begin
          if (!inResp) begin
            checkOutput("rsp_latency", 64'(cyc), 64'(expQ[0].due));
            inResp = 1'b1;
          end
          checkOutput("rsp_id", 64'(bus.rsp_id), 64'(expQ[0].id));
          checkOutput("rsp_sum", 64'(bus.rsp_sum), 64'(expQ[0].res[31:0]));
          checkOutput("rsp_cout", 64'(bus.rsp_cout), 64'(expQ[0].res[32]));
          if (bus.rsp_ready) begin
            void'(expQ.pop_front());
            outstanding = 1'b0;
            inResp      = 1'b0;
            firstCyc    = -1;
          end
        end
      end
    end
  end

  task automatic checkAllZero(input string tag);
    checkOutput({tag, "_req_ready"}, 64'(bus.req_ready), 64'd0);
    checkOutput({tag, "_adder_a"}, 64'(bus.adder_a), 64'd0);
    checkOutput({tag, "_adder_b"}, 64'(bus.adder_b), 64'd0);
    checkOutput({tag, "_adder_cin"}, 64'(bus.adder_cin), 64'd0);
    checkOutput({tag, "_adder_first"}, 64'(bus.adder_first), 64'd0);
    checkOutput({tag, "_rsp_valid"}, 64'(bus.rsp_valid), 64'd0);
    checkOutput({tag, "_rsp_id"}, 64'(bus.rsp_id), 64'd0);
    checkOutput({tag, "_rsp_sum"}, 64'(bus.rsp_sum), 64'd0);
    checkOutput({tag, "_rsp_cout"}, 64'(bus.rsp_cout), 64'd0);
    checkOutput({tag, "_busy"}, 64'(busy), 64'd0);
  endtask

  initial begin
    int n;
    logic [WIDTH-1:0] ra, mask;
    int expOrder[8];

    $display("[TB] reset");
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkAllZero("reset");
    @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed operations");
    applyStimulus(0, 32'h0000_0000, 32'h0000_0000, 1'b0);
    waitDrain(100);
    applyStimulus(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    waitDrain(100);
    applyStimulus(1, 32'h0000_00FF, 32'h0000_FF00, 1'b0);
    waitDrain(100);

    $display("[TB] response backpressure");
    @(negedge clk);
    rspMode = 2;
    applyStimulus(3, 32'h1234_5678, 32'h8765_4321, 1'b1);
    n = 0;
    while (!bus.rsp_valid && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("rsp_wait_timeout", 64'(n >= 100), 64'd0);
    repeat (10) @(negedge clk);
    rspMode = 0;
    waitDrain(100);

    $display("[TB] full rotation");
    grantLog.delete();
    for (int r = 0; r < 2; r++)
      for (int i = 0; i < NREQ; i++)
        applyStimulus(i, 32'(i * 32'h0101_0101), 32'(r * 32'h00FF_00FF), 1'(i & 1));
    waitDrain(400);
    expOrder = '{0, 1, 2, 3, 0, 1, 2, 3};
    checkOutput("rotation_count", 64'(grantLog.size()), 64'd8);
    for (int k = 0; k < 8 && k < grantLog.size(); k++)
      checkOutput("rotation_order", 64'(grantLog[k]), 64'(expOrder[k]));

    $display("[TB] reset during wait");
    applyStimulus(2, 32'hFFFF_FFFF, 32'h0000_0000, 1'b1);
    n = 0;
    while (!bus.adder_first && n < 100) begin
      @(negedge clk);
      n++;
    end
    checkOutput("launch_timeout", 64'(n >= 100), 64'd0);
    @(posedge clk);
    #1 rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    checkAllZero("midreset");
    expQ.delete();
    outstanding = 1'b0;
    inResp      = 1'b0;
    firstCyc    = -1;
    ptrM        = 0;
    @(posedge clk);
    #1 rst_n = 1'b1;
    grantLog.delete();
    applyStimulus(3, 32'h0000_0003, 32'h0000_0004, 1'b0);
    applyStimulus(1, 32'h0000_0001, 32'h0000_0002, 1'b0);
    waitDrain(200);
    checkOutput("post_reset_first_grant", 64'(grantLog.size() > 0 ? grantLog[0] : -1), 64'd1);

    $display("[TB] randomized traffic");
    dropEn  = 1'b1;
    rspMode = 1;
    for (int k = 0; k < 40; k++) begin
      ra   = $urandom;
      mask = $urandom;
      for (int s = 0; s < WIDTH / SEG; s++)
        if ($urandom_range(0, 1) == 1) mask[s*SEG +: SEG] = 8'hFF;
      applyStimulus(int'($urandom_range(0, NREQ - 1)), ra, ra ^ mask, 1'($urandom_range(0, 1)));
    end
    waitDrain(6000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    checkOutput("global_timeout", 64'd1, 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
